dmem_responder: RTL

//  Multi-cycle data-memory responder, the memory-side end of the CPU MEM-stage load/store interface.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_array.sv | 24 ++
 rtl/dmem_responder.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared state encoding, sizing constants and width helper for the dmem_responder slice.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    localparam int WORD_BYTES = 4;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: one port, synchronous write when we_i, read data presented for the
// caller to register. Holds no reset state.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem[idx_i] <= wdata_i;
    end

    assign rdata_o = mem[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: fixed-latency load/store with ack and stall.
// Define DMEM_ALIGN_CHECK_EN to flag misaligned accesses on err_o and suppress their effect.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        stall_o,
    output logic        err_o
);

    localparam int IDX_W   = clog2(DEPTH);
    localparam int IDX_LSB = clog2(WORD_BYTES);
    localparam int CNT_W   = clog2(LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic               mis_q, mis_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        data_q, data_d;
    logic               err_q, err_d;

    logic               req;
    logic               in_mis;
    logic [IDX_W-1:0]   in_idx;
    logic               use_live;
    logic               commit;
    logic               cmt_wr;
    logic               cmt_mis;
    logic [IDX_W-1:0]   cmt_idx;
    logic [31:0]        cmt_wdata;
    logic               arr_we;
    logic [31:0]        arr_rdata;
    logic               unused_addr;

    assign req         = MemRead_i | MemWrite_i;
    assign in_idx      = addr_i[IDX_LSB +: IDX_W];
    assign unused_addr = ^addr_i;

`ifdef DMEM_ALIGN_CHECK_EN
    assign in_mis = |addr_i[IDX_LSB-1:0];
`else
    assign in_mis = 1'b0;
`endif

    // With LATENCY = 1 the commit edge is the accept edge, so the live request feeds the array.
    assign use_live  = (state_q == IDLE);
    assign cmt_wr    = use_live ? MemWrite_i : wr_q;
    assign cmt_mis   = use_live ? in_mis     : mis_q;
    assign cmt_idx   = use_live ? in_idx     : idx_q;
    assign cmt_wdata = use_live ? data_i     : wdata_q;
    assign arr_we    = commit & cmt_wr & ~cmt_mis;

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (arr_we),
        .idx_i   (cmt_idx),
        .wdata_i (cmt_wdata),
        .rdata_o (arr_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        mis_d   = mis_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        err_d   = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    wr_d    = MemWrite_i;
                    mis_d   = in_mis;
                    idx_d   = in_idx;
                    wdata_d = data_i;
                    cnt_d   = CNT_INIT;
                    if (LATENCY == 1) begin
                        state_d = DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                    commit  = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Loads refresh data_o only on commit; a store (including read+write) leaves it alone.
        if (commit) begin
            err_d = cmt_mis;
            if (!cmt_wr) data_d = cmt_mis ? 32'd0 : arr_rdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            mis_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            mis_q   <= mis_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign data_o  = data_q;
    assign ack_o   = (state_q == DONE);
    assign err_o   = ack_o & err_q;
    assign stall_o = req & ~ack_o;

endmodule
